smc_access_sched8: RTL and testbench

- Two-requester arbiter and timing sequencer for the SMC external memory strobe path.
- Grants the external bus to requester 0 or 1 in round-robin order.
- Sequences each access through address, access, hold and turnaround phases; per-phase cycle counts come from the SMC timing configuration fields.
- Sits between the SMC request sources and the external chip-select/strobe drivers.

---
 rtl/smc_access_sched8.sv | 175 +++++++++++++++++
 tb/tb_smc_access_sched8.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/smc_access_sched8.sv
`default_nettype none
// ============================================================================
// Module   : smc_access_sched8
// Purpose  : Two-requester round-robin arbiter and strobe timing sequencer for
//            the SMC external memory path. Each granted access walks through
//            ADDR -> ACCESS -> HOLD -> TURN -> IDLE. The length of each phase
//            comes from the timing configuration, which is captured when the
//            access is granted.
// Ports    : hclk8        - system clock, rising edge
//            sys_rst8     - synchronous active-high reset
//            req8[1:0]    - per-requester access request (level)
//            we8[1:0]     - per-requester direction, 1 = write
//            cfg_rd_ws8   - read wait states (ACCESS lasts ws+1 cycles)
//            cfg_wr_ws8   - write wait states
//            cfg_hold8    - hold cycles after the strobe
//            cfg_turn8    - bus turnaround cycles after the access
//            gnt8[1:0]    - one-hot grant, ADDR through HOLD
//            done8[1:0]   - completion pulse in the last ACCESS cycle
//            smc_cs8      - external chip select
//            smc_oe8      - read strobe
//            smc_we8      - write strobe
//            busy8        - sequencer not idle
// Revision : 1.0 - initial release
// ============================================================================
module smc_access_sched8 #(
    parameter int WS_W = 4
) (
    input  logic            hclk8,
    input  logic            sys_rst8,
    input  logic [1:0]      req8,
    input  logic [1:0]      we8,
    input  logic [WS_W-1:0] cfg_rd_ws8,
    input  logic [WS_W-1:0] cfg_wr_ws8,
    input  logic [1:0]      cfg_hold8,
    input  logic [1:0]      cfg_turn8,
    output logic [1:0]      gnt8,
    output logic [1:0]      done8,
    output logic            smc_cs8,
    output logic            smc_oe8,
    output logic            smc_we8,
    output logic            busy8
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_ADDR   = 3'd1;
    localparam logic [2:0] c_ST_ACCESS = 3'd2;
    localparam logic [2:0] c_ST_HOLD   = 3'd3;
    localparam logic [2:0] c_ST_TURN   = 3'd4;

    // Phase state and the parameters of the access in flight.
    logic [2:0]      r_state;
    logic [WS_W-1:0] r_cnt;      // cycles remaining in the current phase after this one
    logic            r_last;     // requester granted most recently
    logic            r_win;
    logic            r_we;
    logic [1:0]      r_hold;
    logic [1:0]      r_turn;

    logic            w_win;
    logic            w_we;
    logic [WS_W-1:0] w_ws;
    logic            w_arb;
    logic            w_cur_win;
    logic            w_cur_we;
    logic [1:0]      w_win_oh;
    logic [2:0]      w_nxt_state;
    logic [WS_W-1:0] w_nxt_cnt;
    logic            w_nxt_done;
    logic            w_on_bus;

    // Arbitration: on a tie, the requester that was not served last wins.
    assign w_win     = (req8 == 2'b11) ? ~r_last : req8[1];
    assign w_we      = we8[w_win];
    assign w_ws      = w_we ? cfg_wr_ws8 : cfg_rd_ws8;
    assign w_arb     = (r_state == c_ST_IDLE) && (req8 != 2'b00);

    // Outputs are registered against the next state, so on the arbitration
    // edge the freshly selected winner must be used instead of r_win.
    assign w_cur_win = w_arb ? w_win : r_win;
    assign w_cur_we  = w_arb ? w_we  : r_we;
    assign w_win_oh  = w_cur_win ? 2'b10 : 2'b01;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_done  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_arb) begin
                    w_nxt_state = c_ST_ADDR;
                    // Wait-state count rides through ADDR in the counter.
                    w_nxt_cnt   = w_ws;
                end
            end
            c_ST_ADDR: begin
                w_nxt_state = c_ST_ACCESS;
                w_nxt_done  = (r_cnt == '0);
            end
            c_ST_ACCESS: begin
                if (r_cnt != '0) begin
                    w_nxt_cnt  = r_cnt - WS_W'(1);
                    w_nxt_done = (r_cnt == WS_W'(1));
                end else if (r_hold != 2'd0) begin
                    w_nxt_state = c_ST_HOLD;
                    w_nxt_cnt   = WS_W'(r_hold - 2'd1);
                end else if (r_turn != 2'd0) begin
                    w_nxt_state = c_ST_TURN;
                    w_nxt_cnt   = WS_W'(r_turn - 2'd1);
                end else begin
                    w_nxt_state = c_ST_IDLE;
                end
            end
            c_ST_HOLD: begin
                if (r_cnt != '0) begin
                    w_nxt_cnt = r_cnt - WS_W'(1);
                end else if (r_turn != 2'd0) begin
                    w_nxt_state = c_ST_TURN;
                    w_nxt_cnt   = WS_W'(r_turn - 2'd1);
                end else begin
                    w_nxt_state = c_ST_IDLE;
                end
            end
            c_ST_TURN: begin
                if (r_cnt != '0) begin
                    w_nxt_cnt = r_cnt - WS_W'(1);
                end else begin
                    w_nxt_state = c_ST_IDLE;
                end
            end
            default: begin
                w_nxt_state = c_ST_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    assign w_on_bus = (w_nxt_state == c_ST_ADDR) || (w_nxt_state == c_ST_ACCESS) ||
                      (w_nxt_state == c_ST_HOLD);

    always_ff @(posedge hclk8) begin
        if (sys_rst8) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_win   <= 1'b0;
            r_we    <= 1'b0;
            r_hold  <= 2'd0;
            r_turn  <= 2'd0;
            gnt8    <= 2'b00;
            done8   <= 2'b00;
            smc_cs8 <= 1'b0;
            smc_oe8 <= 1'b0;
            smc_we8 <= 1'b0;
            busy8   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            if (w_arb) begin
                r_win  <= w_win;
                r_we   <= w_we;
                r_hold <= cfg_hold8;
                r_turn <= cfg_turn8;
                r_last <= w_win;
            end
            gnt8    <= w_on_bus ? w_win_oh : 2'b00;
            done8   <= w_nxt_done ? w_win_oh : 2'b00;
            smc_cs8 <= w_on_bus;
            smc_oe8 <= (w_nxt_state == c_ST_ACCESS) && !w_cur_we;
            smc_we8 <= (w_nxt_state == c_ST_ACCESS) && w_cur_we;
            busy8   <= (w_nxt_state != c_ST_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_smc_access_sched8.sv
`default_nettype none
// ============================================================================
// Module   : tb_smc_access_sched8
// Purpose  : Self-checking bench for smc_access_sched8. A reference model
//            expands every granted access into its expected per-cycle output
//            timeline and queues it; a monitor pops one entry per cycle and
//            compares it with the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_smc_access_sched8;

    localparam int WS_W = 4;

    logic            hclk8 = 1'b0;
    logic            sys_rst8;
    logic [1:0]      req8;
    logic [1:0]      we8;
    logic [WS_W-1:0] cfg_rd_ws8;
    logic [WS_W-1:0] cfg_wr_ws8;
    logic [1:0]      cfg_hold8;
    logic [1:0]      cfg_turn8;
    logic [1:0]      gnt8;
    logic [1:0]      done8;
    logic            smc_cs8;
    logic            smc_oe8;
    logic            smc_we8;
    logic            busy8;

    smc_access_sched8 #(.WS_W(WS_W)) u_dut (
        .hclk8      (hclk8),
        .sys_rst8   (sys_rst8),
        .req8       (req8),
        .we8        (we8),
        .cfg_rd_ws8 (cfg_rd_ws8),
        .cfg_wr_ws8 (cfg_wr_ws8),
        .cfg_hold8  (cfg_hold8),
        .cfg_turn8  (cfg_turn8),
        .gnt8       (gnt8),
        .done8      (done8),
        .smc_cs8    (smc_cs8),
        .smc_oe8    (smc_oe8),
        .smc_we8    (smc_we8),
        .busy8      (busy8)
    );

    always #5 hclk8 = ~hclk8;

    // Expected output vector per cycle: {gnt[1:0], done[1:0], cs, oe, we, busy}
    logic [7:0] exp_q[$];
    logic       last_m;
    bit         sim_done;
    bit         started;
    bit         auto_drop;
    int         n_tests;
    int         n_fail;
    int         cyc;

    // Reference model: one access is ADDR (1), ACCESS (ws+1, done in the
    // last), HOLD (hold), TURN (turn), followed by one IDLE cycle in which
    // the next arbitration is sampled.
    task automatic schedule_access();
        logic       win;
        logic       wr;
        int         ws;
        int         h;
        int         t;
        logic [1:0] g;
        win = (req8 == 2'b11) ? ~last_m : req8[1];
        wr  = we8[win];
        ws  = wr ? int'(cfg_wr_ws8) : int'(cfg_rd_ws8);
        h   = int'(cfg_hold8);
        t   = int'(cfg_turn8);
        g   = win ? 2'b10 : 2'b01;
        exp_q.push_back({g, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1});
        for (int i = 0; i <= ws; i++)
            exp_q.push_back({g, (i == ws) ? g : 2'b00, 1'b1, ~wr, wr, 1'b1});
        for (int i = 0; i < h; i++)
            exp_q.push_back({g, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1});
        for (int i = 0; i < t; i++)
            exp_q.push_back({2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1});
        exp_q.push_back(8'h00);
        last_m = win;
    endtask

    task automatic tick();
        @(negedge hclk8);
        if (auto_drop) req8 = req8 & ~done8;
    endtask

    task automatic wait_quiet(input string name, input int max_cyc);
        int n;
        n = 0;
        while ((req8 != 2'b00 || busy8 !== 1'b0) && n < max_cyc) begin
            tick();
            n++;
        end
        n_tests++;
        if (n >= max_cyc) begin
            n_fail++;
            $display("FAIL %s_timeout: req8=%b busy8=%b after %0d cycles, required idle", name, req8, busy8, n);
        end
    endtask

    task automatic run_stimulus();
        int n;
        // Reset
        repeat (3) tick();
        sys_rst8 = 1'b0;
        tick();

        // Single read, rd_ws = 2, no hold/turn
        cfg_rd_ws8 = 4'd2; cfg_wr_ws8 = 4'd0; cfg_hold8 = 2'd0; cfg_turn8 = 2'd0;
        we8 = 2'b00; req8 = 2'b01;
        wait_quiet("single_read", 40);
        tick();

        // Both requesters writing continuously
        auto_drop = 1'b0;
        cfg_wr_ws8 = 4'd0; cfg_hold8 = 2'd1; cfg_turn8 = 2'd1;
        we8 = 2'b11; req8 = 2'b11;
        repeat (21) tick();
        req8 = 2'b00;
        auto_drop = 1'b1;
        wait_quiet("rr_writes", 40);
        tick();

        // Config change during an ongoing read
        cfg_rd_ws8 = 4'd1; cfg_hold8 = 2'd0; cfg_turn8 = 2'd0;
        we8 = 2'b00; req8 = 2'b01;
        n = 0;
        while (smc_oe8 !== 1'b1 && n < 20) begin tick(); n++; end
        cfg_rd_ws8 = 4'd5;
        wait_quiet("cfg_change_a", 40);
        req8 = 2'b01;
        wait_quiet("cfg_change_b", 40);
        tick();

        // Reset during the 2nd ACCESS cycle of a rd_ws = 4 read
        cfg_rd_ws8 = 4'd4;
        req8 = 2'b01;
        repeat (3) tick();
        sys_rst8 = 1'b1;
        req8 = 2'b00;
        tick();
        sys_rst8 = 1'b0;
        we8 = 2'b00; req8 = 2'b11;
        wait_quiet("after_reset", 80);
        tick();

        // Maximum wait states
        cfg_rd_ws8 = 4'd15; cfg_hold8 = 2'd2; cfg_turn8 = 2'd3;
        we8 = 2'b00; req8 = 2'b01;
        wait_quiet("max_ws", 60);
        tick();

        // Request dropped in the ADDR cycle
        cfg_rd_ws8 = 4'd3; cfg_hold8 = 2'd0; cfg_turn8 = 2'd0;
        we8 = 2'b00; req8 = 2'b10;
        tick();
        req8 = 2'b00;
        repeat (10) tick();

        // Randomised traffic
        for (int c = 0; c < 800; c++) begin
            tick();
            if ($urandom_range(0, 299) == 0) begin
                sys_rst8 = 1'b1;
                tick();
                sys_rst8 = 1'b0;
            end
            if ($urandom_range(0, 19) == 0) begin
                cfg_rd_ws8 = WS_W'($urandom_range(0, 15));
                cfg_wr_ws8 = WS_W'($urandom_range(0, 15));
                cfg_hold8  = 2'($urandom_range(0, 3));
                cfg_turn8  = 2'($urandom_range(0, 3));
            end
            for (int r = 0; r < 2; r++) begin
                if (!req8[r] && $urandom_range(0, 3) == 0) begin
                    we8[r]  = 1'($urandom_range(0, 1));
                    req8[r] = 1'b1;
                end else if (req8[r] && $urandom_range(0, 31) == 0) begin
                    req8[r] = 1'b0;
                end
            end
        end
        wait_quiet("random_drain", 200);
        repeat (3) tick();
        sim_done = 1'b1;
    endtask

    initial begin
        sys_rst8   = 1'b1;
        req8       = 2'b00;
        we8        = 2'b00;
        cfg_rd_ws8 = '0;
        cfg_wr_ws8 = '0;
        cfg_hold8  = 2'd0;
        cfg_turn8  = 2'd0;
        auto_drop  = 1'b1;
        sim_done   = 1'b0;
        started    = 1'b0;
        last_m     = 1'b1;
        n_tests    = 0;
        n_fail     = 0;
        cyc        = 0;
        fork
            // Reference model: decides at each edge what the next cycles look like.
            begin
                while (!sim_done) begin
                    @(posedge hclk8);
                    started = 1'b1;
                    if (sys_rst8) begin
                        exp_q.delete();
                        last_m = 1'b1;
                        exp_q.push_back(8'h00);
                    end else if (exp_q.size() == 0) begin
                        if (req8 != 2'b00) schedule_access();
                        else exp_q.push_back(8'h00);
                    end
                end
            end
            // Monitor: compares the DUT against the queued expectation each cycle.
            begin
                logic [7:0] got;
                logic [7:0] exp_v;
                while (!sim_done) begin
                    @(negedge hclk8);
                    cyc++;
                    if (started) begin
                        got = {gnt8, done8, smc_cs8, smc_oe8, smc_we8, busy8};
                        n_tests++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL scoreboard_empty cyc=%0d got=%b required an expectation", cyc, got);
                        end else begin
                            exp_v = exp_q.pop_front();
                            if (got !== exp_v) begin
                                n_fail++;
                                $display("FAIL outputs cyc=%0d got {gnt,done,cs,oe,we,busy}=%b required %b",
                                         cyc, got, exp_v);
                            end
                        end
                        n_tests++;
                        if (smc_oe8 === 1'b1 && smc_we8 === 1'b1) begin
                            n_fail++;
                            $display("FAIL strobe_overlap cyc=%0d got oe=%b we=%b required not both high",
                                     cyc, smc_oe8, smc_we8);
                        end
                    end
                end
            end
            begin
                run_stimulus();
            end
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
